// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor with a 2-bit saturating-counter BHT and a direct-mapped BTB.
// Optional performance counters are enabled by defining BRANCH_PRED_PERF_EN.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_btaken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PRED_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_t;

  cnt_state_t          r_cnt     [DEPTH];
  logic                r_btb_v   [DEPTH];
  logic [TAG_BITS-1:0] r_btb_tag [DEPTH];
  logic [XLEN-1:0]     r_btb_tgt [DEPTH];

  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_hit;
  logic                w_pred_taken;
  logic                w_mispredict;
  cnt_state_t          w_cnt_nxt;

  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Fetch lookup: reads pre-edge state only, no bypass from a same-cycle update
  always_comb begin
    w_hit        = r_btb_v[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
    w_pred_taken = w_hit && ((r_cnt[w_if_idx] == WT) || (r_cnt[w_if_idx] == ST));
    pred_taken   = w_pred_taken;
    if (w_pred_taken) begin
      pred_target = r_btb_tgt[w_if_idx];
    end else begin
      pred_target = if_pc + PC_STEP;
    end
  end

  // Resolution check against the prediction carried down the pipe
  always_comb begin
    w_mispredict = ex_valid && ((ex_btaken != ex_pred_taken) ||
                                (ex_btaken && (ex_target != ex_pred_target)));
    mispredict   = w_mispredict;
    if (ex_btaken) begin
      redirect_pc = ex_target;
    end else begin
      redirect_pc = ex_pc + PC_STEP;
    end
  end

  // Counter next-state for the resolving entry: taken moves toward ST, not-taken toward SNT
  always_comb begin
    w_cnt_nxt = r_cnt[w_ex_idx];
    case (r_cnt[w_ex_idx])
      SNT:     w_cnt_nxt = ex_btaken ? WNT : SNT;
      WNT:     w_cnt_nxt = ex_btaken ? WT  : SNT;
      WT:      w_cnt_nxt = ex_btaken ? ST  : WNT;
      ST:      w_cnt_nxt = ex_btaken ? ST  : WT;
      default: w_cnt_nxt = WNT;
    endcase
  end

  // BHT/BTB state; a taken branch overwrites whatever entry aliases its index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i]     <= WNT;
        r_btb_v[i]   <= 1'b0;
        r_btb_tag[i] <= {TAG_BITS{1'b0}};
        r_btb_tgt[i] <= {XLEN{1'b0}};
      end
    end else if (ex_valid) begin
      r_cnt[w_ex_idx] <= w_cnt_nxt;
      if (ex_btaken) begin
        r_btb_v[w_ex_idx]   <= 1'b1;
        r_btb_tag[w_ex_idx] <= w_ex_tag;
        r_btb_tgt[w_ex_idx] <= ex_target;
      end
    end
  end

`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // Free-running event counters, wrapping at 2**32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_branches    <= 32'd0;
      r_perf_mispredicts <= 32'd0;
    end else begin
      if (ex_valid) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (w_mispredict) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule
